screen_fill_engine: RTL
=======================

// Module: screen_fill_engine
// PURPOSE
//  Far end of the game-state controller's screen-counter interface.
//  - Consumes the controller's clear, enable, plot and sel_screen strobes.
//  - Sweeps every pixel of a full-screen bitmap held in an external synchronous ROM.
//  - Streams x/y/colour/writeEn to the VGA adapter.
//  - Returns the `done` flag the controller samples as startup_done / over_done.
//  - One instance per screen counter pair; sel_screen chooses the ROM image.
// PARAMETERS
//  X_MAX     160    pixels per row; x counter wraps at X_MAX-1
//  Y_MAX     120    rows per screen
//  X_W       8      x output width
//  Y_W       7      y output width
//  COLOUR_W  3      colour width (rom_data, colour)
//  ADDR_W    16     ROM address width (must hold 2*X_MAX*Y_MAX-1)
// PORTS
//  clock     in   1         system clock, all logic posedge
//  reset     in   1         synchronous, active-high; highest priority
//  clear_n   in   1         sync active-low clear (controller's reset_*_counter)
//  enable    in   1         controller's enable_*_counter; low = pause
//  plot      in   1         controller's *_plot; sweep starts only with enable&plot
//  sel_screen in  2         0=startup image, 1=game-over image, 2/3=no image
//  rom_addr  out  ADDR_W    ROM address; data returns on rom_data 1 clock later
//  rom_data  in   COLOUR_W  ROM read data
//  x         out  X_W       pixel x to VGA
//  y         out  Y_W       pixel y to VGA
//  colour    out  COLOUR_W  pixel colour to VGA
//  writeEn   out  1         VGA write strobe, one pixel per high cycle
//  done      out  1         full image written; held until clear_n/reset
// BEHAVIOUR
//  Reset (reset=1) or clear_n=0 at a clock edge:
//   - next state IDLE; cx=cy=0; pipeline valids 0.
//   - x=y=colour=0, writeEn=0, done=0, rom_addr=0.
//   - reset wins over clear_n; clear_n wins over enable/plot.
//  FSM states:
//   - IDLE: if enable&plot&sel_screen<2 -> latch base (sel 0: 0; sel 1: X_MAX*Y_MAX) -> SWEEP.
//     sel_screen>=2 stays IDLE, never writes, done stays 0.
//   - SWEEP: each cycle with enable&plot=1:
//     - issue rom_addr = base + cy*X_MAX + cx (ADDR_W unsigned, no overflow).
//     - advance cx; at cx=X_MAX-1, cx->0 and cy++.
//     - after issuing (X_MAX-1,Y_MAX-1) -> DRAIN.
//     - enable or plot low: counters hold, nothing issued, no writes, no skips or duplicates.
//   - DRAIN: wait until pipeline empty (2 cycles) -> DONE.
//   - DONE: done=1, writeEn=0. Ignores enable/plot/sel_screen changes until clear.
//  sel_screen is sampled only on IDLE->SWEEP; later changes are ignored.
//  Pipeline (registered):
//   - stage1 captures (cx,cy,issue) with the address.
//   - stage2: x<=cx1, y<=cy1, colour<=rom_data, writeEn<=issue1.
//   - Issue -> writeEn latency: exactly 2 clocks.
//   - Pause does not flush in-flight pixels; they still retire.
//  Timing: uninterrupted sweep gives X_MAX*Y_MAX consecutive writeEn cycles;
//   done rises X_MAX*Y_MAX+2 clocks after the first issue cycle.
//  Mid-sweep clear/reset: in-flight pixels dropped (writeEn=0 next cycle);
//   a later start restarts from (0,0).
// TESTING
//  1 sel=0, enable=plot=1 from IDLE:
//    - first write (0,0) from addr 0; last write (159,119) from addr 19199.
//    - 19200 writes; done=1 at cycle 19202.
//  2 sel=1 sweep:
//    - first rom_addr=19200, last rom_addr=38399.
//    - colour equals ROM model delayed 1 clock.
//  3 enable low 10 cycles while cx=80, cy=5:
//    - at most 2 in-flight writes retire, then none.
//    - resume gives (80,5) next, no gaps/duplicates; total 19200 writes.
//  4 clear_n=0 at pixel 5000:
//    - writeEn=0 and done=0 next cycle.
//    - restart writes (0,0) first; simultaneous clear_n=0 & enable=1 stays IDLE.
//  5 After done: toggle plot, change sel:
//    - no writes, done held 1.
//    - clear_n pulse drops done; sel=2 with enable=1 never writes.
//  6 reset=1 mid-sweep with clear_n=1: all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/screen_fill_engine.sv
// Full-screen bitmap sweeper: walks every pixel of a ROM image and streams
// x/y/colour/writeEn to the VGA adapter, then raises done until cleared.
module screen_fill_engine #(
   parameter int X_MAX    = 160,
   parameter int Y_MAX    = 120,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int ADDR_W   = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_n,
   input  logic                enable,
   input  logic                plot,
   input  logic [1:0]          sel_screen,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_data,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                writeEn,
   output logic                done
);

   localparam logic [ADDR_W-1:0] IMG_BASE1 = ADDR_W'(X_MAX * Y_MAX);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(X_MAX - 1);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_MAX - 1);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

   state_t state_q, state_d;

   logic                issue;
   logic                load;
   logic                last_px;

   logic [X_W-1:0]      cx_q, cx_d;
   logic [Y_W-1:0]      cy_q, cy_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   logic [X_W-1:0]      cx_p1_q, cx_p1_d;
   logic [Y_W-1:0]      cy_p1_q, cy_p1_d;
   logic                vld_p1_q, vld_p1_d;

   logic [X_W-1:0]      x_p2_q, x_p2_d;
   logic [Y_W-1:0]      y_p2_q, y_p2_d;
   logic [COLOUR_W-1:0] colour_p2_q, colour_p2_d;
   logic                vld_p2_q, vld_p2_d;

   assign last_px = (cx_q == X_LAST) && (cy_q == Y_LAST);

   always_ff @(posedge clock) begin
      if (reset || !clear_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (enable && plot && !sel_screen[1]) state_d = S_SWEEP;
         S_SWEEP: if (issue && last_px)                 state_d = S_DRAIN;
         S_DRAIN: if (!vld_p1_q)                        state_d = S_DONE;
         S_DONE:                                        state_d = S_DONE;
         default:                                       state_d = S_IDLE;
      endcase
   end

   always_comb begin
      issue = 1'b0;
      load  = 1'b0;
      done  = 1'b0;
      case (state_q)
         S_IDLE:  load  = enable && plot && !sel_screen[1];
         S_SWEEP: issue = enable && plot;
         S_DONE:  done  = 1'b1;
         default: ;
      endcase
   end

   // Raster counters; the address tracks the counters incrementally and holds
   // on the final pixel so it never points past the selected image.
   always_comb begin
      cx_d   = cx_q;
      cy_d   = cy_q;
      addr_d = addr_q;
      if (load) begin
         cx_d   = '0;
         cy_d   = '0;
         addr_d = sel_screen[0] ? IMG_BASE1 : '0;
      end else if (issue && !last_px) begin
         addr_d = addr_q + ADDR_W'(1);
         if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = cy_q + Y_W'(1);
         end else begin
            cx_d = cx_q + X_W'(1);
         end
      end
   end

   // Stage 1 travels with the ROM access; stage 2 meets the returned data.
   always_comb begin
      cx_p1_d     = cx_q;
      cy_p1_d     = cy_q;
      vld_p1_d    = issue;
      x_p2_d      = cx_p1_q;
      y_p2_d      = cy_p1_q;
      colour_p2_d = rom_data;
      vld_p2_d    = vld_p1_q;
   end

   always_ff @(posedge clock) begin
      if (reset || !clear_n) begin
         cx_q        <= '0;
         cy_q        <= '0;
         addr_q      <= '0;
         cx_p1_q     <= '0;
         cy_p1_q     <= '0;
         vld_p1_q    <= 1'b0;
         x_p2_q      <= '0;
         y_p2_q      <= '0;
         colour_p2_q <= '0;
         vld_p2_q    <= 1'b0;
      end else begin
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         addr_q      <= addr_d;
         cx_p1_q     <= cx_p1_d;
         cy_p1_q     <= cy_p1_d;
         vld_p1_q    <= vld_p1_d;
         x_p2_q      <= x_p2_d;
         y_p2_q      <= y_p2_d;
         colour_p2_q <= colour_p2_d;
         vld_p2_q    <= vld_p2_d;
      end
   end

   assign rom_addr = addr_q;
   assign x        = x_p2_q;
   assign y        = y_p2_q;
   assign colour   = colour_p2_q;
   assign writeEn  = vld_p2_q;

endmodule
